// File: rtl/rgb_pwm_driver_pkg.sv
// Shared constants for the RGB PWM driver: channel slice bounds in the 24-bit
// light word and the width/terminal value of the PWM phase counter.
package rgb_pwm_driver_pkg;
  localparam int RED_HI = 23;
  localparam int RED_LO = 16;
  localparam int GRN_HI = 15;
  localparam int GRN_LO = 8;
  localparam int BLU_HI = 7;
  localparam int BLU_LO = 0;

  localparam int                 PHASE_W   = 8;
  localparam logic [PHASE_W-1:0] PHASE_MAX = 8'd255;
endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM channel: registered strict compare of phase against duty, gated by enable.
// Output lags phase by one clk; no backpressure.
module pwm_channel
  import rgb_pwm_driver_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] duty,
  output logic               out
);

  logic r_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_raw <= 1'b0;
    else     r_raw <= enable & (phase < duty);
  end

  // Inversion sits after the register so reset also lands on the off level.
  assign out = r_raw ^ INVERT;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit LED PWM with frame-aligned double-buffered RGB word.
// Outputs lag phase by one clk; light is sampled only at frame boundaries (no backpressure).
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter bit INVERT   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        frame_start
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]    r_presc;
  logic [PHASE_W-1:0] r_phase;
  logic [23:0]        r_shadow;
  logic               r_loaded;
  logic               r_frame_start;
  logic               w_tick;
  logic               w_boundary;
  logic               w_load;

  assign w_tick     = (r_presc == PS_W'(PRESCALE - 1));
  assign w_boundary = w_tick && (r_phase == PHASE_MAX);
  // The very first edge after reset also loads, so frame one never shows zeros.
  assign w_load     = w_boundary || !r_loaded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc       <= '0;
      r_phase       <= '0;
      r_shadow      <= '0;
      r_loaded      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + PS_W'(1);
      if (w_tick) r_phase <= r_phase + PHASE_W'(1);
      if (w_load) r_shadow <= light;
      r_loaded      <= 1'b1;
      r_frame_start <= w_load;
    end
  end

  assign frame_start = r_frame_start;

  pwm_channel #(.INVERT(INVERT)) u_red (
    .clk(clk), .rst(rst), .enable(enable), .phase(r_phase),
    .duty(r_shadow[RED_HI:RED_LO]), .out(pwm_r)
  );

  pwm_channel #(.INVERT(INVERT)) u_grn (
    .clk(clk), .rst(rst), .enable(enable), .phase(r_phase),
    .duty(r_shadow[GRN_HI:GRN_LO]), .out(pwm_g)
  );

  pwm_channel #(.INVERT(INVERT)) u_blu (
    .clk(clk), .rst(rst), .enable(enable), .phase(r_phase),
    .duty(r_shadow[BLU_HI:BLU_LO]), .out(pwm_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: three instances (PRESCALE=1, PRESCALE=4, inverted)
// share stimulus; per-frame high counts are compared against hand-computed values.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [23:0] light = 24'hFF0000;

  logic r1, g1, b1, fs1;
  logic r4, g4, b4, fs4;
  logic ri, gi, bi, fsi;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1), .INVERT(1'b0)) u_p1 (
    .clk(clk), .rst(rst), .enable(enable), .light(light),
    .pwm_r(r1), .pwm_g(g1), .pwm_b(b1), .frame_start(fs1)
  );

  rgb_pwm_driver #(.PRESCALE(4), .INVERT(1'b0)) u_p4 (
    .clk(clk), .rst(rst), .enable(enable), .light(light),
    .pwm_r(r4), .pwm_g(g4), .pwm_b(b4), .frame_start(fs4)
  );

  rgb_pwm_driver #(.PRESCALE(1), .INVERT(1'b1)) u_inv (
    .clk(clk), .rst(rst), .enable(enable), .light(light),
    .pwm_r(ri), .pwm_g(gi), .pwm_b(bi), .frame_start(fsi)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // {r, g, b, frame_start} of the selected instance
  function automatic logic [3:0] pick(input int sel);
    case (sel)
      1:       return {r4, g4, b4, fs4};
      2:       return {ri, gi, bi, fsi};
      default: return {r1, g1, b1, fs1};
    endcase
  endfunction

  // Waits for frame_start, then counts high cycles over one frame of outputs.
  // per = sample index at which the following frame_start appears.
  task automatic measure(input int sel, input bit now,
                         input int en_off, input int en_on,
                         input int chg_at, input logic [23:0] chg_val,
                         output int nr, output int ng, output int nb, output int per);
    int w;
    int len;
    logic [3:0] s;
    len = (sel == 1) ? 1024 : 256;
    nr = 0; ng = 0; nb = 0; per = 0;
    if (!now) @(negedge clk);
    w = 0;
    s = pick(sel);
    while (!s[0] && w < 3000) begin
      @(negedge clk);
      w++;
      s = pick(sel);
    end
    chk("fs_seen", int'(s[0]), 1);
    if (!s[0]) return;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      s = pick(sel);
      nr += int'(s[3]);
      ng += int'(s[2]);
      nb += int'(s[1]);
      if (s[0] && per == 0) per = i;
      if (i == en_off) enable = 1'b0;
      if (i == en_on)  enable = 1'b1;
      if (i == chg_at) light = chg_val;
    end
  endtask

  initial begin
    int nr, ng, nb, per, n;

    // Reset, then run into the middle of a frame
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_pwm_r", int'(r1), 0);
    chk("rst_pwm_g", int'(g1), 0);
    chk("rst_pwm_b", int'(b1), 0);
    chk("rst_fs", int'(fs1), 0);
    chk("rst_inv_r", int'(ri), 1);
    chk("rst_inv_g", int'(gi), 1);
    chk("rst_inv_b", int'(bi), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("first_load_fs", int'(fs1), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs1 && n < 600);
    chk("first_frame_gap", n, 255);

    // Single channel, PRESCALE=1
    measure(0, 1'b0, 0, 0, 0, 24'h0, nr, ng, nb, per);
    chk("red_only_r", nr, 255);
    chk("red_only_g", ng, 0);
    chk("red_only_b", nb, 0);
    chk("red_only_period", per, 256);

    // Duty scaling with PRESCALE=4
    light = 24'h804001;
    measure(1, 1'b0, 0, 0, 0, 24'h0, nr, ng, nb, per);
    chk("ps4_r", nr, 512);
    chk("ps4_g", ng, 256);
    chk("ps4_b", nb, 4);
    chk("ps4_period", per, 1024);

    // Double buffer: change mid-frame, takes effect next frame
    light = 24'h100000;
    measure(0, 1'b0, 0, 0, 0, 24'h0, nr, ng, nb, per);
    measure(0, 1'b1, 0, 0, 100, 24'hF00000, nr, ng, nb, per);
    chk("dbuf_cur_r", nr, 16);
    measure(0, 1'b1, 0, 0, 0, 24'h0, nr, ng, nb, per);
    chk("dbuf_next_r", nr, 240);
    chk("dbuf_period", per, 256);

    // Enable gating for 50 clks mid-frame
    light = 24'hFF0000;
    measure(0, 1'b0, 50, 100, 0, 24'h0, nr, ng, nb, per);
    chk("gate_r", nr, 205);
    chk("gate_period", per, 256);

    // Near-white, normal and inverted polarity
    light = 24'hFFFFFF;
    measure(0, 1'b0, 0, 0, 0, 24'h0, nr, ng, nb, per);
    chk("white_r", nr, 255);
    chk("white_g", ng, 255);
    chk("white_b", nb, 255);
    measure(2, 1'b0, 0, 0, 0, 24'h0, nr, ng, nb, per);
    chk("white_inv_r", nr, 1);
    chk("white_inv_g", ng, 1);
    chk("white_inv_b", nb, 1);
    chk("white_inv_period", per, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream stage of the colour converter. Consumes the 24-bit RGB word (the `rgb`/`light` value) and drives three physical LED pins with 8-bit pulse-width modulation, one pin per channel. The RGB word is double-buffered and only takes effect at PWM frame boundaries, so the LEDs never glitch mid-frame. A one-cycle frame pulse is exported for benches and for future brightness/fade logic.

Parameters:
PRESCALE, 4, clk cycles per PWM phase step; must be >= 1; frame length = 256*PRESCALE clk cycles.
INVERT, 0, 1 = active-low LED pins (all three outputs inverted after gating, including the reset value).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = drive LEDs; 0 = force outputs to the off level
light  input  24  RGB word: [23:16] red duty, [15:8] green duty, [7:0] blue duty
pwm_r  output  1  red LED drive
pwm_g  output  1  green LED drive
pwm_b  output  1  blue LED drive
frame_start  output  1  one-clk pulse marking the first phase of each frame

Behaviour:
- Reset (async, immediate, also mid-frame): prescaler=0, phase=0, shadow=0, loaded=0, frame_start=0, pwm_x = INVERT.
- Prescaler counts 0..PRESCALE-1 and wraps; tick = (prescaler == PRESCALE-1). With PRESCALE=1, tick is asserted every cycle.
- Phase is an 8-bit counter, incremented on tick; 255 wraps to 0.
- Frame boundary = tick while phase==255.
  - At a frame boundary: shadow <= light, and frame_start <= 1 for exactly one clk, aligned with the cycle in which phase first reads 0.
- First load: on the first clk edge after rst deasserts, shadow <= light, loaded <= 1, and frame_start pulses. The first frame therefore uses valid data, not zeros.
- Output stage is registered. Each clk edge: raw_x <= enable & (phase < shadow_x), then pwm_x = raw_x ^ INVERT.
  - Outputs lag phase by 1 clk.
  - The comparison is strict unsigned 8-bit.
- Duty rules:
  - duty 0 -> never on.
  - duty N -> on for exactly N*PRESCALE clks per frame.
  - duty 255 -> on 255/256 of the frame.
  - 0xFFFFFF is therefore near-white, not DC.
- Mid-frame change on light: ignored until the next frame boundary.
- enable=0: outputs go to the off level on the next clk edge. Prescaler, phase, frame_start and shadow loading continue unaffected, so frame timing never shifts.
- enable toggled mid-frame: gating applies per cycle. The remainder of the frame resumes with the current shadow duty.
- Simultaneous frame boundary and light change on the same edge: the value present on light at that edge is captured.

Decomposition:
- Shared package holds:
  - channel slice constants: RED_HI=23, RED_LO=16, GRN_HI=15, GRN_LO=8, BLU_HI=7, BLU_LO=0
  - PHASE_W=8 and PHASE_MAX=255
- Sub-module pwm_channel (clk, rst, enable, phase[7:0], duty[7:0], out): registered compare-and-gate with INVERT parameter, instantiated three times.
- Prescaler, phase counter, shadow register and frame_start stay in rgb_pwm_driver.

Test Plan:
1. Reset values: PRESCALE=1, INVERT=0, assert rst mid-frame -> pwm_r/g/b=0 and frame_start=0 immediately (before the next edge); phase restarts at 0 after release, and the first-load frame_start pulse follows the first edge.
2. Single channel: light=0xFF0000, enable=1, PRESCALE=1 -> per 256-clk frame, pwm_r high exactly 255 clks, pwm_g/pwm_b high 0 clks; frame_start pulses exactly every 256 clks.
3. Duty and prescale: PRESCALE=4, light=0x804001 -> per 1024-clk frame, high counts r=512, g=256, b=4.
4. Double-buffer: at phase 100, change light from 0x100000 to 0xF00000 -> the current frame shows 16 high clks; the next frame (after frame_start) shows 240.
5. Enable gating: drop enable mid-frame for 50 clks -> all outputs 0 from the next edge; frame_start period unchanged (still 256*PRESCALE).
6. Chain with converter: converter enable=1 feeding white (0xFFFFFF) -> each channel high 255 of 256 phases. With INVERT=1, the same test gives the outputs low 255 of 256 phases and high during reset.
